// File: rtl/load_store_unit.sv
// Load/store unit between a single-cycle core and a valid/ready word bus.
// Define LSU_TIMEOUT_EN to build the response timeout counter and bus_err reporting.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] RESET_RDATA    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [2:0]  core_funct3,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic [31:0] core_rdata,
    output logic        core_done,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RESP,
        DONE
    } state_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("load_store_unit: TIMEOUT_CYCLES must be in [1, 65535]");
    end

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [31:0] rdata_q, rdata_d;
    logic        misalign_q, misalign_d;
`ifdef LSU_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        buserr_q, buserr_d;
`endif

    logic        req_bad;
    logic [31:0] lane_word;
    logic [31:0] load_ext;
    logic [3:0]  strb;
    logic [31:0] wdata_lanes;

    // Illegal size codes and unaligned accesses never reach the bus.
    always_comb begin
        req_bad = 1'b0;
        case (core_funct3)
            3'b000, 3'b100: req_bad = 1'b0;
            3'b001, 3'b101: req_bad = core_addr[0];
            3'b010:         req_bad = |core_addr[1:0];
            default:        req_bad = 1'b1;
        endcase
        if (core_we && core_funct3[2]) begin
            req_bad = 1'b1;
        end
    end

    always_comb begin
        lane_word = mem_rdata >> {addr_q[1:0], 3'b000};
        case (funct3_q)
            3'b000:  load_ext = {{24{lane_word[7]}}, lane_word[7:0]};
            3'b001:  load_ext = {{16{lane_word[15]}}, lane_word[15:0]};
            3'b100:  load_ext = {24'h0, lane_word[7:0]};
            3'b101:  load_ext = {16'h0, lane_word[15:0]};
            default: load_ext = lane_word;
        endcase
    end

    always_comb begin
        case (funct3_q[1:0])
            2'b00: begin
                strb        = 4'b0001 << addr_q[1:0];
                wdata_lanes = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                strb        = 4'b0011 << addr_q[1:0];
                wdata_lanes = {2{wdata_q[15:0]}};
            end
            default: begin
                strb        = 4'b1111;
                wdata_lanes = wdata_q;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        funct3_d   = funct3_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        rdata_d    = rdata_q;
        misalign_d = misalign_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d      = cnt_q;
        buserr_d   = buserr_q;
`endif
        case (state_q)
            IDLE: begin
                if (core_req) begin
                    addr_d     = core_addr;
                    funct3_d   = core_funct3;
                    wdata_d    = core_wdata;
                    we_d       = core_we;
                    misalign_d = req_bad;
`ifdef LSU_TIMEOUT_EN
                    buserr_d   = 1'b0;
                    cnt_d      = '0;
`endif
                    if (req_bad) begin
                        rdata_d = RESET_RDATA;
                        state_d = DONE;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_ready) begin
                    state_d = we_q ? DONE : WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (mem_rvalid) begin
                    rdata_d = load_ext;
                    state_d = DONE;
                end
`ifdef LSU_TIMEOUT_EN
                // A response on the last allowed cycle takes priority over the timeout.
                else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    rdata_d  = RESET_RDATA;
                    buserr_d = 1'b1;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            funct3_q   <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            rdata_q    <= RESET_RDATA;
            misalign_q <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt_q      <= '0;
            buserr_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            funct3_q   <= funct3_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q      <= cnt_d;
            buserr_q   <= buserr_d;
`endif
        end
    end

    assign core_done  = (state_q == DONE);
    assign stall      = core_req & ~core_done;
    assign misalign   = core_done & misalign_q;
    assign core_rdata = rdata_q;
`ifdef LSU_TIMEOUT_EN
    assign bus_err    = core_done & buserr_q;
`else
    assign bus_err    = 1'b0;
`endif

    assign mem_valid  = (state_q == REQ);
    assign mem_we     = mem_valid & we_q;
    assign mem_addr   = mem_valid ? {addr_q[31:2], 2'b00} : '0;
    assign mem_wstrb  = mem_valid ? strb : '0;
    assign mem_wdata  = mem_valid ? wdata_lanes : '0;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly downstream of the single-cycle core's data-memory port. Replaces the core's direct combinational data-memory hookup.
- Takes the core's load/store request (address = ALU result, store data = rs2 value, funct3 size code).
- Drives a valid/ready word-wide external memory bus with byte strobes, and returns aligned, sign/zero-extended load data.
- Stalls the core until the access completes, and flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles spent in WAIT_RESP before aborting; must be >= 1 and < 2^16.
- RESET_RDATA, 32'h0000_0000, value of core_rdata after reset and on error.

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, asynchronous active-low reset.
- core_req, input, 1, core holds high for a load/store, sampled in IDLE.
- core_we, input, 1, 1 = store, 0 = load.
- core_funct3, input, 3, RV32I size code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- core_addr, input, 32, byte address.
- core_wdata, input, 32, store data, right-justified.
- core_rdata, output, 32, extended load result, valid when core_done=1.
- core_done, output, 1, one-cycle completion pulse.
- stall, output, 1, freezes the core PC/regfile write.
- misalign, output, 1, one-cycle pulse alongside core_done.
- bus_err, output, 1, one-cycle pulse alongside core_done on timeout.
- mem_valid, output, 1, bus request.
- mem_ready, input, 1, bus accepts request.
- mem_we, output, 1, bus write.
- mem_addr, output, 32, word address; bits [1:0] are always 0.
- mem_wstrb, output, 4, byte enables.
- mem_wdata, output, 32, lane-shifted store data.
- mem_rvalid, input, 1, read data valid.
- mem_rdata, input, 32, read word.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All outputs 0, except core_rdata=RESET_RDATA. Timeout counter=0.
- Reset mid-transaction: the transaction is abandoned, mem_valid drops immediately, and no core_done is issued.
- stall = core_req & ~core_done (combinational).
- FSM states: IDLE, REQ, WAIT_RESP, DONE.
- IDLE, core_req=1:
  - Address, funct3, wdata and we are latched.
  - Misalignment check: halfword with addr[0]≠0, word with addr[1:0]≠0, or an illegal funct3 (011, 11x, or store with 1xx). Any of these goes to DONE with misalign=1 and no bus activity.
  - Otherwise goes to REQ.
- REQ: mem_valid=1, with mem_addr/mem_we/mem_wstrb/mem_wdata held stable until the cycle where mem_ready=1.
  - Handshake on a store: go to DONE.
  - Handshake on a load: go to WAIT_RESP.
  - mem_rvalid in the same cycle as mem_ready is ignored; the response must arrive at least one cycle later.
- WAIT_RESP: mem_valid=0 and the counter increments each cycle.
  - mem_rvalid=1: capture the extended data, go to DONE.
  - Counter reaches TIMEOUT_CYCLES: go to DONE with bus_err=1 and core_rdata=RESET_RDATA.
  - mem_rvalid and timeout in the same cycle: data wins, no bus_err.
- DONE: core_done=1 for exactly one cycle. Always returns to IDLE; a new request is accepted from the next cycle.
- Minimum latency: store = 3 cycles from core_req to core_done (IDLE, REQ, DONE) with mem_ready tied high; load = 4.
- Strobes:
  - Byte: wstrb = 0001 << addr[1:0].
  - Halfword: wstrb = 0011 << addr[1:0].
  - Word: wstrb = 1111.
  - mem_wdata replicates the byte or halfword across all lanes.
- Load extract: select the lane by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
- core_rdata holds its value until the next load completes. Stores do not change it.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- Defined: timeout counter and bus_err behave as specified above.
- Undefined: the counter is not built, WAIT_RESP waits indefinitely, and bus_err is tied to 0. TIMEOUT_CYCLES is ignored.

Test Plan:
- SW addr 0x0000_0104, wdata 0xDEADBEEF, mem_ready=1 -> mem_addr 0x104, wstrb 1111, mem_wdata 0xDEADBEEF. core_done on cycle 3, stall low after.
- SB addr 0x0000_0103, wdata 0x0000_00A5 -> wstrb 1000, mem_wdata 0xA5A5A5A5.
- LB addr 0x0000_0102, mem_rdata 0x1280_3456 returned 2 cycles late -> core_rdata 0xFFFF_FF80. The same access with LBU -> core_rdata 0x0000_0080.
- LW addr 0x0000_0006 -> misalign pulse with core_done two cycles after the request, mem_valid never asserted.
- LW with mem_rvalid withheld, TIMEOUT_CYCLES=4, macro defined -> bus_err with core_done, core_rdata 0.
- rst asserted while in WAIT_RESP -> mem_valid 0 and core_done 0 immediately. A new LHU to 0x0000_0002 with mem_rdata 0xBEEF_0000 -> core_rdata 0x0000_BEEF.
